alu_op_sequencer: RTL and testbench

- Initiator-side controller for the team's N-bit combinational ALU (operands a/b, 4-bit select, N-bit result).
- Accepts operation commands over a valid/ready interface and drives registered operands and select onto the ALU.
- Waits a programmable settle time, captures the ALU result, and returns it over a valid/ready response interface.
- Supports chained operations, where operand A is taken from the previous captured result. This lets a host stream multi-step computations without reading back intermediate values.

---
 rtl/alu_op_sequencer.sv | 137 +++++++++++++
 tb/tb_alu_op_sequencer.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: initiator-side controller for a combinational ALU.
// Accepts a command, drives registered operands/select onto the ALU, waits
// SETTLE cycles, captures the result and returns it over a valid/ready
// response channel. Chained commands reuse the last captured result as A.
module alu_op_sequencer #(
  parameter int N      = 8,
  parameter int SETTLE = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         cmd_valid,
  output logic         cmd_ready,
  input  logic [N-1:0] cmd_a,
  input  logic [N-1:0] cmd_b,
  input  logic [3:0]   cmd_select,
  input  logic         cmd_chain,
  output logic [N-1:0] alu_a,
  output logic [N-1:0] alu_b,
  output logic [3:0]   alu_select,
  input  logic [N-1:0] alu_result,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic [N-1:0] rsp_result,
  output logic [15:0]  op_count
);

  // Settle counter must hold SETTLE-1; keep at least one bit for SETTLE=1.
  localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETTLE,
    S_RESP
  } state_t;

  state_t        r_state,      w_state_next;
  logic [CW-1:0] r_cnt,        w_cnt_next;
  logic [N-1:0]  r_alu_a,      w_alu_a_next;
  logic [N-1:0]  r_alu_b,      w_alu_b_next;
  logic [3:0]    r_alu_select, w_alu_select_next;
  logic [N-1:0]  r_rsp_result, w_rsp_result_next;
  logic [N-1:0]  r_last,       w_last_next;
  logic [15:0]   r_op_count,   w_op_count_next;
  logic          r_cmd_ready,  w_cmd_ready_next;
  logic          r_rsp_valid,  w_rsp_valid_next;

  // State and datapath registers; reset discards any in-flight command.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_cnt        <= '0;
      r_alu_a      <= '0;
      r_alu_b      <= '0;
      r_alu_select <= '0;
      r_rsp_result <= '0;
      r_last       <= '0;
      r_op_count   <= '0;
      r_cmd_ready  <= 1'b0;
      r_rsp_valid  <= 1'b0;
    end else begin
      r_state      <= w_state_next;
      r_cnt        <= w_cnt_next;
      r_alu_a      <= w_alu_a_next;
      r_alu_b      <= w_alu_b_next;
      r_alu_select <= w_alu_select_next;
      r_rsp_result <= w_rsp_result_next;
      r_last       <= w_last_next;
      r_op_count   <= w_op_count_next;
      r_cmd_ready  <= w_cmd_ready_next;
      r_rsp_valid  <= w_rsp_valid_next;
    end
  end

  // Next-state and next-output logic; handshake flags are registered so
  // every output is glitch-free and cmd_ready stays low during reset.
  always_comb begin
    w_state_next      = r_state;
    w_cnt_next        = r_cnt;
    w_alu_a_next      = r_alu_a;
    w_alu_b_next      = r_alu_b;
    w_alu_select_next = r_alu_select;
    w_rsp_result_next = r_rsp_result;
    w_last_next       = r_last;
    w_op_count_next   = r_op_count;
    w_cmd_ready_next  = r_cmd_ready;
    w_rsp_valid_next  = r_rsp_valid;

    case (r_state)
      S_IDLE: begin
        if (cmd_valid && r_cmd_ready) begin
          w_alu_a_next      = cmd_chain ? r_last : cmd_a;
          w_alu_b_next      = cmd_b;
          w_alu_select_next = cmd_select;
          w_cnt_next        = CW'(SETTLE - 1);
          w_cmd_ready_next  = 1'b0;
          w_state_next      = S_SETTLE;
        end else begin
          w_cmd_ready_next  = 1'b1;
        end
      end
      S_SETTLE: begin
        w_cmd_ready_next = 1'b0;
        if (r_cnt == '0) begin
          w_rsp_result_next = alu_result;
          w_last_next       = alu_result;
          w_rsp_valid_next  = 1'b1;
          w_state_next      = S_RESP;
        end else begin
          w_cnt_next = r_cnt - 1'b1;
        end
      end
      S_RESP: begin
        w_cmd_ready_next = 1'b0;
        if (r_rsp_valid && rsp_ready) begin
          w_rsp_valid_next = 1'b0;
          w_op_count_next  = r_op_count + 16'd1;
          w_cmd_ready_next = 1'b1;
          w_state_next     = S_IDLE;
        end
      end
      default: begin
        w_state_next     = S_IDLE;
        w_cmd_ready_next = 1'b0;
        w_rsp_valid_next = 1'b0;
      end
    endcase
  end

  assign cmd_ready  = r_cmd_ready;
  assign rsp_valid  = r_rsp_valid;
  assign rsp_result = r_rsp_result;
  assign alu_a      = r_alu_a;
  assign alu_b      = r_alu_b;
  assign alu_select = r_alu_select;
  assign op_count   = r_op_count;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Self-checking bench for alu_op_sequencer: a SETTLE=1 instance driven by a
// bench ALU model with a result scoreboard, plus a SETTLE=3 instance whose
// ALU result is driven directly to check the sampling edge.
module tb_alu_op_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;

  // SETTLE=1 instance signals
  logic        cmd_valid, cmd_ready, cmd_chain;
  logic [7:0]  cmd_a, cmd_b;
  logic [3:0]  cmd_select;
  logic [7:0]  alu_a, alu_b, alu_result;
  logic [3:0]  alu_select;
  logic        rsp_valid, rsp_ready;
  logic [7:0]  rsp_result;
  logic [15:0] op_count;

  // SETTLE=3 instance signals
  logic        c3_valid, c3_ready, c3_chain;
  logic [7:0]  c3_a, c3_b;
  logic [3:0]  c3_select;
  logic [7:0]  c3_alu_a, c3_alu_b, c3_alu_result;
  logic [3:0]  c3_alu_select;
  logic        c3_rsp_valid, c3_rsp_ready;
  logic [7:0]  c3_rsp_result;
  logic [15:0] c3_op_count;

  int          n_checks = 0;
  int          n_errors = 0;
  logic [7:0]  sb_q[$];
  logic [7:0]  model_last;
  logic [15:0] exp_count;

  always #5 clk = ~clk;

  function automatic logic [7:0] model(input logic [7:0] a, input logic [7:0] b,
                                       input logic [3:0] s);
    if (s == 4'd0)      return a + b;
    else if (s == 4'd1) return a - b;
    else                return a ^ b;
  endfunction

  assign alu_result = model(alu_a, alu_b, alu_select);

  alu_op_sequencer #(.N(8), .SETTLE(1)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_select(cmd_select), .cmd_chain(cmd_chain),
    .alu_a(alu_a), .alu_b(alu_b), .alu_select(alu_select), .alu_result(alu_result),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
    .op_count(op_count)
  );

  alu_op_sequencer #(.N(8), .SETTLE(3)) dut3 (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(c3_valid), .cmd_ready(c3_ready),
    .cmd_a(c3_a), .cmd_b(c3_b), .cmd_select(c3_select), .cmd_chain(c3_chain),
    .alu_a(c3_alu_a), .alu_b(c3_alu_b), .alu_select(c3_alu_select),
    .alu_result(c3_alu_result),
    .rsp_valid(c3_rsp_valid), .rsp_ready(c3_rsp_ready), .rsp_result(c3_rsp_result),
    .op_count(c3_op_count)
  );

  // Present a command at a negedge, wait (bounded) for acceptance, push the
  // expected result and check the registered ALU operands.
  task automatic accept_cmd(input logic [7:0] a, input logic [7:0] b,
                            input logic [3:0] sel, input logic chain);
    logic [7:0] ea;
    int n;
    cmd_a = a; cmd_b = b; cmd_select = sel; cmd_chain = chain; cmd_valid = 1'b1;
    n = 0;
    while (cmd_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    n_checks++;
    if (n >= 50) begin
      n_errors++;
      $display("FAIL accept_timeout: cmd_ready=%b required 1 within 50 cycles", cmd_ready);
    end
    ea = chain ? model_last : a;
    sb_q.push_back(model(ea, b, sel));
    @(negedge clk);
    cmd_valid = 1'b0;
    n_checks++;
    if ({alu_a, alu_b, alu_select} !== {ea, b, sel}) begin
      n_errors++;
      $display("FAIL alu_operands: got a=%h b=%h sel=%h required a=%h b=%h sel=%h",
               alu_a, alu_b, alu_select, ea, b, sel);
    end
    n_checks++;
    if (cmd_ready !== 1'b0) begin
      n_errors++;
      $display("FAIL cmd_ready_after_accept: got %b required 0", cmd_ready);
    end
  endtask

  // Wait (bounded) for a response, pop and compare, then complete the
  // handshake and check the counter and ready reassertion.
  task automatic collect_rsp();
    logic [7:0] exp;
    int n;
    n = 0;
    while (rsp_valid !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    n_checks++;
    if (n >= 50) begin
      n_errors++;
      $display("FAIL rsp_timeout: rsp_valid=%b required 1 within 50 cycles", rsp_valid);
    end
    exp = (sb_q.size() > 0) ? sb_q.pop_front() : 8'h00;
    rsp_ready = 1'b1;
    n_checks++;
    if (rsp_result !== exp) begin
      n_errors++;
      $display("FAIL rsp_result: got %h required %h", rsp_result, exp);
    end
    $display("txn a=%h b=%h sel=%0d result=%h expected=%h", alu_a, alu_b, alu_select,
             rsp_result, exp);
    model_last = exp;
    exp_count  = exp_count + 16'd1;
    @(negedge clk);
    n_checks++;
    if ({rsp_valid, cmd_ready, op_count} !== {1'b0, 1'b1, exp_count}) begin
      n_errors++;
      $display("FAIL post_handshake: got valid=%b ready=%b count=%0d required 0 1 %0d",
               rsp_valid, cmd_ready, op_count, exp_count);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    cmd_valid = 0; cmd_a = 0; cmd_b = 0; cmd_select = 0; cmd_chain = 0; rsp_ready = 1;
    c3_valid = 0; c3_a = 0; c3_b = 0; c3_select = 0; c3_chain = 0; c3_rsp_ready = 0;
    c3_alu_result = 0;
    model_last = 8'h00;
    exp_count  = 16'd0;
    repeat (2) @(negedge clk);
    n_checks++;
    if ({alu_a, alu_b, alu_select, rsp_result, op_count, cmd_ready, rsp_valid} !== '0) begin
      n_errors++;
      $display("FAIL reset_state: got a=%h b=%h sel=%h res=%h cnt=%h rdy=%b vld=%b required all 0",
               alu_a, alu_b, alu_select, rsp_result, op_count, cmd_ready, rsp_valid);
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    n_checks++;
    if (cmd_ready !== 1'b1) begin
      n_errors++;
      $display("FAIL ready_after_reset: got %b required 1", cmd_ready);
    end
    // accept a command, then reset while it is settling
    cmd_a = 8'h10; cmd_b = 8'h22; cmd_select = 4'd0; cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    n_checks++;
    if (alu_a !== 8'h10) begin
      n_errors++;
      $display("FAIL reset_pre_accept: got alu_a=%h required 10", alu_a);
    end
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({alu_a, alu_b, cmd_ready, rsp_valid} !== '0) begin
      n_errors++;
      $display("FAIL async_reset: got a=%h b=%h rdy=%b vld=%b required all 0",
               alu_a, alu_b, cmd_ready, rsp_valid);
    end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (i == 1) rst_n = 1'b1;
      n_checks++;
      if (rsp_valid !== 1'b0) begin
        n_errors++;
        $display("FAIL reset_no_rsp: cycle %0d got rsp_valid=%b required 0", i, rsp_valid);
      end
    end
    n_checks++;
    if ({cmd_ready, op_count, rsp_result} !== {1'b1, 16'd0, 8'h00}) begin
      n_errors++;
      $display("FAIL reset_release: got rdy=%b cnt=%0d res=%h required 1 0 00",
               cmd_ready, op_count, rsp_result);
    end
  endtask

  task automatic test_chain_first();
    accept_cmd(8'hAB, 8'd7, 4'd0, 1'b1);
    collect_rsp();
  endtask

  task automatic test_single();
    accept_cmd(8'd200, 8'd100, 4'd0, 1'b0);
    collect_rsp();
  endtask

  task automatic test_chain();
    accept_cmd(8'd5, 8'd3, 4'd0, 1'b0);
    collect_rsp();
    accept_cmd(8'h77, 8'd10, 4'd1, 1'b1);
    collect_rsp();
    accept_cmd(8'h00, 8'hFF, 4'd2, 1'b1);
    collect_rsp();
    n_checks++;
    if (model_last !== 8'h01) begin
      n_errors++;
      $display("FAIL chain_final: got %h required 01", model_last);
    end
  endtask

  task automatic test_backpressure();
    int n;
    rsp_ready = 1'b0;
    accept_cmd(8'h33, 8'h11, 4'd1, 1'b0);
    n = 0;
    while (rsp_valid !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    for (int i = 0; i < 6; i++) begin
      cmd_valid = i[0];
      cmd_a = 8'hEE; cmd_b = 8'hDD; cmd_select = 4'd5; cmd_chain = 1'b0;
      n_checks++;
      if ({rsp_valid, rsp_result, cmd_ready, op_count, alu_a} !==
          {1'b1, 8'h22, 1'b0, exp_count, 8'h33}) begin
        n_errors++;
        $display("FAIL backpressure: cycle %0d got vld=%b res=%h rdy=%b cnt=%0d a=%h required 1 22 0 %0d 33",
                 i, rsp_valid, rsp_result, cmd_ready, op_count, alu_a, exp_count);
      end
      @(negedge clk);
    end
    cmd_valid = 1'b0;
    collect_rsp();
  endtask

  task automatic test_settle3();
    c3_a = 8'h01; c3_b = 8'h02; c3_select = 4'd9; c3_alu_result = 8'hAA;
    c3_valid = 1'b1;
    n_checks++;
    if (c3_ready !== 1'b1) begin
      n_errors++;
      $display("FAIL s3_ready: got %b required 1", c3_ready);
    end
    @(posedge clk);              // edge k: accept
    @(negedge clk);
    c3_valid = 1'b0;
    @(posedge clk);              // edge k+1
    @(posedge clk);              // edge k+2
    #1 c3_alu_result = 8'h55;
    @(negedge clk);
    n_checks++;
    if (c3_rsp_valid !== 1'b0) begin
      n_errors++;
      $display("FAIL s3_early: got rsp_valid=%b required 0 before edge k+3", c3_rsp_valid);
    end
    @(negedge clk);              // after edge k+3
    n_checks++;
    if ({c3_rsp_valid, c3_rsp_result, c3_alu_select} !== {1'b1, 8'h55, 4'd9}) begin
      n_errors++;
      $display("FAIL s3_capture: got vld=%b res=%h sel=%h required 1 55 9",
               c3_rsp_valid, c3_rsp_result, c3_alu_select);
    end
    $display("txn settle3 sel=%0d result=%h expected=55", c3_alu_select, c3_rsp_result);
    c3_rsp_ready = 1'b1;
    @(negedge clk);
    c3_rsp_ready = 1'b0;
    n_checks++;
    if ({c3_rsp_valid, c3_op_count} !== {1'b0, 16'd1}) begin
      n_errors++;
      $display("FAIL s3_count: got vld=%b cnt=%0d required 0 1", c3_rsp_valid, c3_op_count);
    end
  endtask

  task automatic test_sweep();
    logic [15:0] base;
    base = op_count;
    for (int s = 0; s < 16; s++) begin
      accept_cmd(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 4'(s), 1'b0);
      collect_rsp();
    end
    n_checks++;
    if (op_count !== base + 16'd16) begin
      n_errors++;
      $display("FAIL sweep_count: got %0d required %0d", op_count, base + 16'd16);
    end
  endtask

  initial begin
    test_reset();
    test_chain_first();
    test_single();
    test_chain();
    test_backpressure();
    test_settle3();
    test_sweep();
    n_checks++;
    if (sb_q.size() != 0) begin
      n_errors++;
      $display("FAIL scoreboard_drain: got %0d entries left required 0", sb_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
